// File: rtl/mult_arb.sv
// Round-robin arbiter sharing one pipelined 64x64 multiplier among NREQ requesters.
// Issued ids travel alongside the multiplier pipeline so each product returns to its requester.
module mult_arb #(
    parameter int NREQ    = 4,
    parameter int LAT     = 18,
    parameter int MAX_OUT = 8
) (
    input  logic                 ck,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      i_req,
    input  logic [64*NREQ-1:0]   i_a,
    input  logic [64*NREQ-1:0]   i_b,
    output logic [NREQ-1:0]      o_gnt,
    output logic [63:0]          o_mul_a,
    output logic [63:0]          o_mul_b,
    output logic                 o_mul_vld,
    input  logic [63:0]          i_mul_res,
    input  logic                 i_mul_vld,
    output logic [63:0]          o_res,
    output logic [NREQ-1:0]      o_res_vld,
    output logic                 o_busy,
    output logic                 o_err
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(MAX_OUT);
    localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

    function automatic logic [NREQ-1:0] id_to_onehot(input logic [IDW-1:0] id);
        logic [NREQ-1:0] oh;
        oh = '0;
        for (int k = 0; k < NREQ; k++) begin
            oh[k] = (IDW'(k) == id) ? 1'b1 : 1'b0;
        end
        return oh;
    endfunction

    logic [CW-1:0]   count_r [NREQ];
    logic [NREQ-1:0] elig_s;
    logic [IDW-1:0]  last_r;
    logic [NREQ-1:0] gnt_s;
    logic            gnt_any_s;
    logic [IDW-1:0]  gnt_id_s;
    logic [63:0]     sel_a_s;
    logic [63:0]     sel_b_s;
    logic            mul_vld_r;
    logic [63:0]     mul_a_r;
    logic [63:0]     mul_b_r;
    logic [IDW-1:0]  issue_id_r;
    logic [LAT-1:0]  tag_v_r;
    logic [IDW-1:0]  tag_id_r [LAT];
    logic            head_v_s;
    logic [IDW-1:0]  head_id_s;
    logic [63:0]     res_r;
    logic [NREQ-1:0] res_vld_r;
    logic            err_r;
    logic            busy_s;

    // Eligibility uses registered counts only, so a return never frees a slot in its own cycle.
    always_comb begin
        elig_s = '0;
        for (int k = 0; k < NREQ; k++) begin
            elig_s[k] = i_req[k] && (count_r[k] < CNT_MAX);
        end
    end

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        gnt_s     = '0;
        gnt_any_s = 1'b0;
        gnt_id_s  = last_r;
        sel_a_s   = '0;
        sel_b_s   = '0;
        for (int off = 1; off <= NREQ; off++) begin
            int j;
            j = (int'(last_r) + off) % NREQ;
            if (!gnt_any_s && elig_s[j]) begin
                gnt_s[j]  = 1'b1;
                gnt_any_s = 1'b1;
                gnt_id_s  = IDW'(j);
                sel_a_s   = i_a[j*64 +: 64];
                sel_b_s   = i_b[j*64 +: 64];
            end else begin
                gnt_id_s  = gnt_id_s;
            end
        end
    end

    assign o_gnt = rst_n ? gnt_s : '0;

    // Issue stage: operand registers hold their value when no grant occurred.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            mul_vld_r  <= 1'b0;
            mul_a_r    <= 64'h0;
            mul_b_r    <= 64'h0;
            issue_id_r <= '0;
            last_r     <= LAST_RST;
        end else begin
            mul_vld_r <= gnt_any_s;
            if (gnt_any_s) begin
                mul_a_r    <= sel_a_s;
                mul_b_r    <= sel_b_s;
                issue_id_r <= gnt_id_s;
                last_r     <= gnt_id_s;
            end
        end
    end

    // Tag pipe fed from the issue register so its head lines up with the multiplier output.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            tag_v_r <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_id_r[i] <= '0;
            end
        end else begin
            tag_v_r[0]  <= mul_vld_r;
            tag_id_r[0] <= issue_id_r;
            for (int i = 1; i < LAT; i++) begin
                tag_v_r[i]  <= tag_v_r[i-1];
                tag_id_r[i] <= tag_id_r[i-1];
            end
        end
    end

    assign head_v_s  = tag_v_r[LAT-1];
    assign head_id_s = tag_id_r[LAT-1];

    // Return routing and sticky mismatch flag.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            res_r     <= 64'h0;
            res_vld_r <= '0;
            err_r     <= 1'b0;
        end else begin
            if (head_v_s && i_mul_vld) begin
                res_r     <= i_mul_res;
                res_vld_r <= id_to_onehot(head_id_s);
            end else begin
                res_vld_r <= '0;
            end
            if (head_v_s ^ i_mul_vld) begin
                err_r <= 1'b1;
            end
        end
    end

    // In-flight counters: decrement follows the registered result pulse.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREQ; k++) begin
                count_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                case ({gnt_s[k], res_vld_r[k]})
                    2'b10:   count_r[k] <= (count_r[k] < CNT_MAX) ? count_r[k] + CW'(1) : count_r[k];
                    2'b01:   count_r[k] <= (count_r[k] != '0) ? count_r[k] - CW'(1) : count_r[k];
                    default: count_r[k] <= count_r[k];
                endcase
            end
        end
    end

    // Busy whenever any requester has work outstanding.
    always_comb begin
        busy_s = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            busy_s = busy_s | (count_r[k] != '0);
        end
    end

    assign o_mul_vld = mul_vld_r;
    assign o_mul_a   = mul_a_r;
    assign o_mul_b   = mul_b_r;
    assign o_res     = res_r;
    assign o_res_vld = res_vld_r;
    assign o_err     = err_r;
    assign o_busy    = busy_s;

endmodule
